// File: rtl/mul52_pkg.sv
// mul52_pkg: shared constants and issue FSM state for the mul52 issue controller.
package mul52_pkg;
    localparam int MUL52_DATA_W    = 52;
    localparam int MUL52_ISSUE_GAP = 9;
    localparam int MUL52_LATENCY   = 13;
    typedef enum logic {IDLE, GAP} issue_state_e;
endpackage

// File: rtl/mul52_sync_fifo.sv
// mul52_sync_fifo: registered-pointer synchronous FIFO, same-cycle push+pop when not full.
module mul52_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, rd_q;
    assign o_empty = wr_q == rd_q;
    assign o_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign o_head  = mem_q[rd_q[AW-1:0]];
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (i_push && !o_full) wr_q <= wr_q + 1'b1;
            if (i_pop && !o_empty) rd_q <= rd_q + 1'b1;
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_push && !o_full) mem_q[wr_q[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/mul52_issue_ctrl.sv
// mul52_issue_ctrl: buffers operand pairs, paces i_en pulses to the mul52 core and returns caller tags.
module mul52_issue_ctrl
    import mul52_pkg::*;
#(
    parameter int DATA_W     = MUL52_DATA_W,
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int ISSUE_GAP  = MUL52_ISSUE_GAP,
    parameter int MAX_OUT    = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [TAG_W-1:0]  i_tag,
    output logic              o_mul_en,
    output logic [DATA_W-1:0] o_mul_a,
    output logic [DATA_W-1:0] o_mul_b,
    input  logic              i_mul_c_en,
    output logic              o_res_tag_vld,
    output logic [TAG_W-1:0]  o_res_tag,
    output logic              o_busy,
    output logic              o_err
);
    localparam int OP_W  = 2*DATA_W + TAG_W;
    localparam int CNT_W = $clog2(ISSUE_GAP);
    localparam int OUT_W = $clog2(MAX_OUT + 1);
    issue_state_e      state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [OUT_W-1:0]  out_q;
    logic              mul_en_q, err_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic              op_full, op_empty, tag_full, tag_empty;
    logic [OP_W-1:0]   op_head, head;
    logic [TAG_W-1:0]  tag_head;
    logic              push, issue, ret;
    assign o_ready = !op_full;
    assign push    = i_valid && !op_full;
    // An empty FIFO is bypassed so a fresh pair can issue in the very next cycle.
    assign head    = op_empty ? {i_a, i_b, i_tag} : op_head;
    assign issue   = state_q == IDLE && (!op_empty || push) && out_q < OUT_W'(MAX_OUT) && !tag_full;
    assign ret     = i_mul_c_en && out_q != '0;
    mul52_sync_fifo #(.WIDTH(OP_W), .DEPTH(FIFO_DEPTH)) u_op_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push && !(issue && op_empty)),
        .i_data  ({i_a, i_b, i_tag}),
        .i_pop   (issue && !op_empty),
        .o_full  (op_full),
        .o_empty (op_empty),
        .o_head  (op_head)
    );
    mul52_sync_fifo #(.WIDTH(TAG_W), .DEPTH(MAX_OUT)) u_tag_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (issue),
        .i_data  (head[TAG_W-1:0]),
        .i_pop   (ret),
        .o_full  (tag_full),
        .o_empty (tag_empty),
        .o_head  (tag_head)
    );
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            out_q    <= '0;
            mul_en_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            err_q    <= 1'b0;
        end else begin
            mul_en_q <= issue;
            if (issue) begin
                a_q <= head[OP_W-1 -: DATA_W];
                b_q <= head[TAG_W +: DATA_W];
            end
            out_q <= out_q + OUT_W'(issue) - OUT_W'(ret);
            if (i_mul_c_en && out_q == '0) err_q <= 1'b1;
            if (state_q == IDLE) begin
                if (issue) begin
                    state_q <= GAP;
                    cnt_q   <= CNT_W'(ISSUE_GAP - 1);
                end
            end else begin
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_q <= IDLE;
            end
        end
    end
    assign o_mul_en      = mul_en_q;
    assign o_mul_a       = a_q;
    assign o_mul_b       = b_q;
    assign o_res_tag_vld = ret;
    assign o_res_tag     = tag_head;
    assign o_busy        = !op_empty || !tag_empty || state_q != IDLE;
    assign o_err         = err_q;
endmodule

// File: tb/tb_mul52_issue_ctrl.sv
// tb_mul52_issue_ctrl: directed tests against a 13-cycle core delay model or manual c_en.
module tb_mul52_issue_ctrl;
    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic [51:0] i_a = '0;
    logic [51:0] i_b = '0;
    logic [3:0]  i_tag = '0;
    logic        man_c_en = 1'b0;
    logic        auto_ret = 1'b0;
    logic [12:0] dly = '0;
    logic        i_mul_c_en;
    logic        o_ready, o_mul_en, o_res_tag_vld, o_busy, o_err;
    logic [51:0] o_mul_a, o_mul_b;
    logic [3:0]  o_res_tag;
    int          vec = 0;
    int          err = 0;

    mul52_issue_ctrl dut (
        .i_clk         (clk),
        .i_rst_n       (i_rst_n),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_a           (i_a),
        .i_b           (i_b),
        .i_tag         (i_tag),
        .o_mul_en      (o_mul_en),
        .o_mul_a       (o_mul_a),
        .o_mul_b       (o_mul_b),
        .i_mul_c_en    (i_mul_c_en),
        .o_res_tag_vld (o_res_tag_vld),
        .o_res_tag     (o_res_tag),
        .o_busy        (o_busy),
        .o_err         (o_err)
    );

    always #5 clk = ~clk;
    // Core stand-in: o_c_en follows i_en by 13 cycles; not reset with the DUT.
    always @(posedge clk) dly <= {dly[11:0], o_mul_en};
    assign i_mul_c_en = auto_ret ? dly[12] : man_c_en;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst_n  = 1'b0;
        i_valid  = 1'b0;
        man_c_en = 1'b0;
        repeat (2) @(posedge clk);
        #3 i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        auto_ret = 1'b0;
        do_reset();
        vec++; if (o_ready !== 1'b1) begin err++; $display("FAIL rst_ready: got %b want 1", o_ready); end
        vec++; if (o_mul_en !== 1'b0) begin err++; $display("FAIL rst_mul_en: got %b want 0", o_mul_en); end
        vec++; if (o_busy !== 1'b0) begin err++; $display("FAIL rst_busy: got %b want 0", o_busy); end
        vec++; if (o_err !== 1'b0) begin err++; $display("FAIL rst_err: got %b want 0", o_err); end
        vec++; if (o_mul_a !== 52'd0 || o_mul_b !== 52'd0) begin err++; $display("FAIL rst_ab: got %h/%h want 0/0", o_mul_a, o_mul_b); end
        i_valid = 1'b1; i_a = 52'd11; i_b = 52'd22; i_tag = 4'd1;
        tick();
        i_valid = 1'b0;
        vec++; if (o_mul_en !== 1'b1 || o_mul_a !== 52'd11) begin err++; $display("FAIL pre_async_issue: got en=%b a=%0d want en=1 a=11", o_mul_en, o_mul_a); end
        #2 i_rst_n = 1'b0;
        #1;
        vec++; if (o_mul_en !== 1'b0 || o_mul_a !== 52'd0 || o_mul_b !== 52'd0) begin err++; $display("FAIL async_clear: got en=%b a=%0d b=%0d want 0", o_mul_en, o_mul_a, o_mul_b); end
        vec++; if (o_busy !== 1'b0 || o_ready !== 1'b1) begin err++; $display("FAIL async_busy_ready: got busy=%b ready=%b want 0/1", o_busy, o_ready); end
        i_rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic signed [103:0] p;
        bit bad = 0;
        auto_ret = 1'b1;
        do_reset();
        i_valid = 1'b1; i_a = 52'd3; i_b = 52'(-5); i_tag = 4'd7;
        tick();
        i_valid = 1'b0;
        vec++; if (o_mul_en !== 1'b1 || o_mul_a !== 52'd3 || o_mul_b !== 52'(-5)) begin err++; $display("FAIL single_issue: got en=%b a=%h b=%h want en=1 a=3 b=-5", o_mul_en, o_mul_a, o_mul_b); end
        for (int c = 2; c <= 13; c++) begin
            tick();
            if (o_mul_en !== 1'b0 || o_res_tag_vld !== 1'b0 || o_mul_a !== 52'd3) bad = 1;
        end
        vec++; if (bad) begin err++; $display("FAIL single_quiet: got extra en/vld or a not held, want none"); end
        tick();
        p = $signed(o_mul_a) * $signed(o_mul_b);
        vec++; if (o_res_tag_vld !== 1'b1 || o_res_tag !== 4'd7) begin err++; $display("FAIL single_return: got vld=%b tag=%0d want vld=1 tag=7", o_res_tag_vld, o_res_tag); end
        vec++; if (p !== 104'(-15)) begin err++; $display("FAIL single_product: got %0d want -15", p); end
        tick();
        vec++; if (o_res_tag_vld !== 1'b0 || o_busy !== 1'b0) begin err++; $display("FAIL single_idle: got vld=%b busy=%b want 0/0", o_res_tag_vld, o_busy); end
    endtask

    task automatic test_burst();
        int acc = 0, en_n = 0, ret_n = 0;
        bit took;
        auto_ret = 1'b1;
        do_reset();
        for (int c = 0; c < 70; c++) begin
            i_valid = acc < 6;
            i_a = 52'(100 + acc); i_b = 52'(-(acc + 1)); i_tag = 4'(acc + 1);
            took = i_valid && o_ready;
            #1;
            if (c == 4) begin vec++; if (o_ready !== 1'b1) begin err++; $display("FAIL burst_ready_c4: got %b want 1", o_ready); end end
            if (c == 5 || c == 9) begin vec++; if (o_ready !== 1'b0) begin err++; $display("FAIL burst_full_c%0d: got %b want 0", c, o_ready); end end
            if (c == 10) begin vec++; if (o_ready !== 1'b1) begin err++; $display("FAIL burst_ready_c10: got %b want 1", o_ready); end end
            if (o_mul_en || (en_n < 6 && c == 1 + 9*en_n)) begin
                vec++;
                if (!(o_mul_en && en_n < 6 && c == 1 + 9*en_n && o_mul_a == 52'(100 + en_n) && o_mul_b == 52'(-(en_n + 1))))
                    begin err++; $display("FAIL burst_issue%0d: got en=%b a=%0d at cycle %0d want en=1 a=%0d at cycle %0d", en_n, o_mul_en, o_mul_a, c, 100 + en_n, 1 + 9*en_n); end
                en_n++;
            end
            if (o_res_tag_vld || (ret_n < 6 && c == 14 + 9*ret_n)) begin
                vec++;
                if (!(o_res_tag_vld && ret_n < 6 && c == 14 + 9*ret_n && o_res_tag == 4'(ret_n + 1)))
                    begin err++; $display("FAIL burst_ret%0d: got vld=%b tag=%0d at cycle %0d want tag=%0d at cycle %0d", ret_n, o_res_tag_vld, o_res_tag, c, ret_n + 1, 14 + 9*ret_n); end
                ret_n++;
            end
            tick();
            if (took) acc++;
        end
        i_valid = 1'b0;
        vec++; if (acc != 6 || en_n != 6 || ret_n != 6) begin err++; $display("FAIL burst_counts: got acc=%0d issues=%0d rets=%0d want 6/6/6", acc, en_n, ret_n); end
        vec++; if (o_busy !== 1'b0) begin err++; $display("FAIL burst_idle: got busy=%b want 0", o_busy); end
    endtask

    task automatic test_withhold();
        bit exp_en, exp_vld;
        logic [3:0] exp_tag;
        auto_ret = 1'b0;
        do_reset();
        for (int c = 0; c <= 50; c++) begin
            i_valid = c < 3; i_a = 52'(c + 1); i_b = 52'd2; i_tag = 4'(9 + c);
            man_c_en = c == 30 || c == 36 || c == 46;
            #1;
            exp_en  = c == 1 || c == 10 || c == 32;
            exp_vld = man_c_en;
            exp_tag = c == 30 ? 4'd9 : c == 36 ? 4'd10 : 4'd11;
            if (o_mul_en || exp_en) begin vec++; if (o_mul_en !== exp_en) begin err++; $display("FAIL hold_en_c%0d: got %b want %b", c, o_mul_en, exp_en); end end
            if (o_res_tag_vld || exp_vld) begin vec++; if (o_res_tag_vld !== exp_vld || o_res_tag !== exp_tag) begin err++; $display("FAIL hold_ret_c%0d: got vld=%b tag=%0d want vld=%b tag=%0d", c, o_res_tag_vld, o_res_tag, exp_vld, exp_tag); end end
            if (c == 25) begin vec++; if (o_mul_a !== 52'd2) begin err++; $display("FAIL hold_a_held: got %0d want 2", o_mul_a); end end
            if (c == 33) begin vec++; if (o_mul_a !== 52'd3) begin err++; $display("FAIL hold_a_third: got %0d want 3", o_mul_a); end end
            tick();
        end
        i_valid = 1'b0; man_c_en = 1'b0;
        vec++; if (o_busy !== 1'b0 || o_err !== 1'b0) begin err++; $display("FAIL hold_end: got busy=%b err=%b want 0/0", o_busy, o_err); end
    endtask

    task automatic test_same_cycle();
        bit exp_en, exp_vld;
        logic [3:0] exp_tag;
        auto_ret = 1'b0;
        do_reset();
        for (int c = 0; c <= 34; c++) begin
            i_valid = c < 2 || c == 10; i_a = 52'(c + 40); i_b = 52'd1; i_tag = c == 0 ? 4'd3 : c == 1 ? 4'd4 : 4'd5;
            man_c_en = c == 9 || c == 25 || c == 30;
            #1;
            exp_en  = c == 1 || c == 10 || c == 19;
            exp_vld = man_c_en;
            exp_tag = c == 9 ? 4'd3 : c == 25 ? 4'd4 : 4'd5;
            if (o_mul_en || exp_en) begin vec++; if (o_mul_en !== exp_en) begin err++; $display("FAIL same_en_c%0d: got %b want %b", c, o_mul_en, exp_en); end end
            if (o_res_tag_vld || exp_vld) begin vec++; if (o_res_tag_vld !== exp_vld || o_res_tag !== exp_tag) begin err++; $display("FAIL same_ret_c%0d: got vld=%b tag=%0d want vld=%b tag=%0d", c, o_res_tag_vld, o_res_tag, exp_vld, exp_tag); end end
            tick();
        end
        i_valid = 1'b0; man_c_en = 1'b0;
        vec++; if (o_busy !== 1'b0 || o_err !== 1'b0) begin err++; $display("FAIL same_end: got busy=%b err=%b want 0/0", o_busy, o_err); end
    endtask

    task automatic test_err();
        auto_ret = 1'b0;
        do_reset();
        man_c_en = 1'b1;
        #1;
        vec++; if (o_res_tag_vld !== 1'b0) begin err++; $display("FAIL stray_vld: got %b want 0", o_res_tag_vld); end
        tick();
        man_c_en = 1'b0;
        vec++; if (o_err !== 1'b1) begin err++; $display("FAIL stray_err: got %b want 1", o_err); end
        repeat (3) tick();
        vec++; if (o_err !== 1'b1 || o_busy !== 1'b0) begin err++; $display("FAIL stray_sticky: got err=%b busy=%b want 1/0", o_err, o_busy); end
        do_reset();
        vec++; if (o_err !== 1'b0) begin err++; $display("FAIL err_reset: got %b want 0", o_err); end
        auto_ret = 1'b1;
        for (int c = 0; c <= 25; c++) begin
            i_valid = c < 2; i_a = 52'(c + 7); i_b = 52'd3; i_tag = 4'(c + 12);
            #1;
            if (c == 1 || c == 10 || (c > 12 && o_mul_en)) begin vec++; if (o_mul_en !== (c == 1 || c == 10)) begin err++; $display("FAIL flush_en_c%0d: got %b", c, o_mul_en); end end
            if (c == 12) begin
                #1 i_rst_n = 1'b0;
                #1;
                vec++; if (o_busy !== 1'b0 || o_err !== 1'b0) begin err++; $display("FAIL flush_clear: got busy=%b err=%b want 0/0", o_busy, o_err); end
                i_rst_n = 1'b1;
            end
            if (c == 14 || c == 23) begin vec++; if (i_mul_c_en !== 1'b1 || o_res_tag_vld !== 1'b0) begin err++; $display("FAIL flush_vld_c%0d: got c_en=%b vld=%b want 1/0", c, i_mul_c_en, o_res_tag_vld); end end
            if (c == 15 || c == 25) begin vec++; if (o_err !== 1'b1) begin err++; $display("FAIL flush_err_c%0d: got %b want 1", c, o_err); end end
            tick();
        end
        i_valid = 1'b0;
        auto_ret = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_withhold();
        test_same_cycle();
        test_err();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
